// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - eight-phase fetch/decode/execute control sequencer
module cpu_sequencer #(
    parameter int PHASES = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             En_cpu_in,
    input  logic [2:0]       Opcode,
    input  logic             SKZ_cmp,
    output logic [2:0]       phase,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             inc_pc,
    output logic             Load_in,
    output logic             ld_ac,
    output logic             wr,
    output logic             data_e,
    output logic             halt,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam phase_e LAST_PHASE = phase_e'(3'(PHASES - 1));

    phase_e           phase_q, phase_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic active;
    logic aluop;
    logic is_hlt;

    // Strobes are suppressed while reset is held, so enable gating includes it.
    assign active = reset && En_cpu_in && !halted_q;
    assign aluop  = (Opcode == OP_ADD) || (Opcode == OP_AND) ||
                    (Opcode == OP_XOR) || (Opcode == OP_LDA);
    assign is_hlt = (Opcode == OP_HLT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (En_cpu_in && !halted_q) begin
            if (phase_q == OP_ADDR && is_hlt) begin
                halted_d = 1'b1;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
                if (phase_q == LAST_PHASE) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel     = 1'b0;
        rd      = 1'b0;
        ld_ir   = 1'b0;
        inc_pc  = 1'b0;
        Load_in = 1'b0;
        ld_ac   = 1'b0;
        wr      = 1'b0;
        data_e  = 1'b0;
        halt    = halted_q;
        if (active) begin
            unique case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd      = aluop;
                    inc_pc  = (Opcode == OP_SKZ) && SKZ_cmp;
                    Load_in = (Opcode == OP_JMP);
                    data_e  = (Opcode == OP_STO);
                end
                STORE: begin
                    rd      = aluop;
                    ld_ac   = aluop;
                    Load_in = (Opcode == OP_JMP);
                    wr      = (Opcode == OP_STO);
                    data_e  = (Opcode == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase       = phase_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       En_cpu_in;
    logic [2:0] Opcode;
    logic       SKZ_cmp;
    logic [2:0] phase;
    logic       sel, rd, ld_ir, inc_pc, Load_in, ld_ac, wr, data_e, halt;
    logic [7:0] instr_count;

    int checks = 0;
    int errors = 0;

    cpu_sequencer #(.PHASES(8), .CNT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .En_cpu_in   (En_cpu_in),
        .Opcode      (Opcode),
        .SKZ_cmp     (SKZ_cmp),
        .phase       (phase),
        .sel         (sel),
        .rd          (rd),
        .ld_ir       (ld_ir),
        .inc_pc      (inc_pc),
        .Load_in     (Load_in),
        .ld_ac       (ld_ac),
        .wr          (wr),
        .data_e      (data_e),
        .halt        (halt),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    // Strobe bundle order: {sel, rd, ld_ir, inc_pc, Load_in, ld_ac, wr, data_e}
    logic [7:0] strb;
    assign strb = {sel, rd, ld_ir, inc_pc, Load_in, ld_ac, wr, data_e};

    typedef struct {
        string            name;
        logic [2:0]       op;
        logic             skz;
        logic [7:0][7:0]  exp;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Reference strobes straight from the phase/opcode rules.
    function automatic logic [7:0] ref_strobes(input int ph, input logic [2:0] op, input logic skz);
        bit alu, s, r, li, ip, ld, la, w, de;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        s   = (ph < 4);
        r   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        li  = (ph == 2 || ph == 3);
        ip  = (ph == 4) || (ph == 6 && op == 3'd1 && skz);
        ld  = (ph >= 6) && (op == 3'd7);
        la  = (ph == 7) && alu;
        w   = (ph == 7) && (op == 3'd6);
        de  = (ph >= 6) && (op == 3'd6);
        return {s, r, li, ip, ld, la, w, de};
    endfunction

    vec_t vt[6];

    initial begin
        int   ticks;
        bit   mhalted;
        bit   en_r;
        int   ph;

        vt[0] = '{"add", 3'd2, 1'b0, {8'b01000100, 8'b01000000, 8'b01000000, 8'b00010000,
                                      8'b11100000, 8'b11100000, 8'b11000000, 8'b10000000}};
        vt[1] = '{"skz_taken", 3'd1, 1'b1, {8'b00000000, 8'b00010000, 8'b00000000, 8'b00010000,
                                            8'b11100000, 8'b11100000, 8'b11000000, 8'b10000000}};
        vt[2] = '{"skz_not", 3'd1, 1'b0, {8'b00000000, 8'b00000000, 8'b00000000, 8'b00010000,
                                          8'b11100000, 8'b11100000, 8'b11000000, 8'b10000000}};
        vt[3] = '{"jmp", 3'd7, 1'b1, {8'b00001000, 8'b00001000, 8'b00000000, 8'b00010000,
                                      8'b11100000, 8'b11100000, 8'b11000000, 8'b10000000}};
        vt[4] = '{"sto", 3'd6, 1'b0, {8'b00000011, 8'b00000001, 8'b00000000, 8'b00010000,
                                      8'b11100000, 8'b11100000, 8'b11000000, 8'b10000000}};
        vt[5] = '{"xor", 3'd4, 1'b1, {8'b01000100, 8'b01000000, 8'b01000000, 8'b00010000,
                                      8'b11100000, 8'b11100000, 8'b11000000, 8'b10000000}};

        // Reset asserted with enable high: everything quiet, including sel.
        reset = 1'b0; En_cpu_in = 1'b1; Opcode = 3'd2; SKZ_cmp = 1'b0;
        #3;
        chk("rst_phase", phase, 0);
        chk("rst_strobes", strb, 0);
        chk("rst_halt", halt, 0);
        chk("rst_count", instr_count, 0);
        tick();
        reset = 1'b1;

        for (int v = 0; v < 6; v++) begin
            do_reset();
            En_cpu_in = 1'b1;
            Opcode    = vt[v].op;
            SKZ_cmp   = vt[v].skz;
            for (int p = 0; p < 8; p++) begin
                #1;
                chk({vt[v].name, "_phase"}, phase, p);
                chk({vt[v].name, "_strb"}, strb, vt[v].exp[p]);
                tick();
            end
            chk({vt[v].name, "_wrap_phase"}, phase, 0);
            chk({vt[v].name, "_count"}, instr_count, 1);
        end

        // Halt entry and persistence.
        do_reset();
        Opcode = 3'd2;
        repeat (8) tick();
        repeat (4) tick();
        Opcode = 3'd0;
        #1;
        chk("hlt_pre_halt", halt, 1);
        chk("hlt_pre_phase", phase, 4);
        tick();
        chk("hlt_phase", phase, 4);
        chk("hlt_halt", halt, 1);
        chk("hlt_strobes", strb, 0);
        Opcode = 3'd2;
        repeat (20) tick();
        chk("hlt_phase_hold", phase, 4);
        chk("hlt_count_hold", instr_count, 1);
        chk("hlt_halt_hold", halt, 1);
        chk("hlt_strobes_hold", strb, 0);
        reset = 1'b0;
        #1;
        chk("hlt_rst_phase", phase, 0);
        chk("hlt_rst_halt", halt, 0);
        tick();
        reset = 1'b1;

        // Enable dropped in phase 5 for three clocks.
        do_reset();
        Opcode = 3'd2;
        repeat (5) tick();
        En_cpu_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("en_low_phase", phase, 5);
            chk("en_low_strb", strb, 0);
            tick();
        end
        En_cpu_in = 1'b1;
        #1;
        chk("en_resume_strb", strb, 8'b01000000);
        tick();
        chk("en_resume_phase", phase, 6);

        // Counter wrap after 256 instructions.
        do_reset();
        Opcode = 3'd5;
        repeat (255 * 8) tick();
        chk("cnt_255", instr_count, 255);
        repeat (8) tick();
        chk("cnt_wrap", instr_count, 0);
        chk("cnt_wrap_phase", phase, 0);

        // Randomized run against a tick-count model.
        do_reset();
        ticks = 0;
        mhalted = 0;
        for (int c = 0; c < 3000; c++) begin
            En_cpu_in = ($urandom % 6) != 0;
            Opcode    = 3'($urandom % 8);
            if (Opcode == 3'd0 && ($urandom % 4) != 0) Opcode = 3'd3;
            SKZ_cmp   = 1'($urandom % 2);
            reset     = ($urandom % 80) != 0;
            if (!reset) begin
                ticks = 0;
                mhalted = 0;
            end
            en_r = reset && En_cpu_in && !mhalted;
            ph = ticks % 8;
            #1;
            chk("rnd_phase", phase, ph);
            chk("rnd_count", instr_count, (ticks / 8) % 256);
            chk("rnd_strb", strb, en_r ? ref_strobes(ph, Opcode, SKZ_cmp) : 8'd0);
            chk("rnd_halt", halt, mhalted || (en_r && ph == 4 && Opcode == 3'd0));
            @(posedge clock);
            if (reset && En_cpu_in && !mhalted) begin
                if (ph == 4 && Opcode == 3'd0) mhalted = 1;
                else ticks++;
            end
            #2;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Eight-phase control sequencer for the 8-bit RISC CPU. It steps every instruction through fetch, decode and execute phases and decodes the current 3-bit opcode into the strobes that drive the datapath: the address mux, memory read/write, instruction-register load, accumulator load, and the program counter's increment and load inputs. It sits directly upstream of the program counter, whose `Load_in` and increment controls come from this block. It also provides a sticky halt and a retired-instruction counter.

## Interface

Parameters:
- `PHASES`, 8: phases per instruction; fixed, not to be overridden.
- `CNT_W`, 8: width of the retired-instruction counter.

Ports:
- `clock`, in, 1: single system clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `En_cpu_in`, in, 1: run enable; when low the sequencer freezes.
- `Opcode`, in, 3: opcode from the instruction register.
- `SKZ_cmp`, in, 1: accumulator-zero flag from the ALU.
- `phase`, out, 3: current phase, 0–7.
- `sel`, out, 1: address mux select; 1 selects PC, 0 selects the IR operand field.
- `rd`, out, 1: memory read strobe.
- `ld_ir`, out, 1: instruction-register load.
- `inc_pc`, out, 1: program-counter increment.
- `Load_in`, out, 1: program-counter load (jump).
- `ld_ac`, out, 1: accumulator load.
- `wr`, out, 1: memory write strobe.
- `data_e`, out, 1: accumulator-to-data-bus drive enable.
- `halt`, out, 1: sticky halted indication.
- `instr_count`, out, CNT_W: retired-instruction count.

## Operation

- Opcode encoding:
  - HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
  - ALUOP = ADD, AND, XOR or LDA.
- State:
  - 3-bit `phase` register.
  - `halted` flag.
  - `instr_count` register.
- Strobes are decoded combinationally from `phase`, `Opcode` and `SKZ_cmp`. Any strobe not listed for a phase is 0.
  - Phase 0, INST_ADDR: sel.
  - Phase 1, INST_FETCH: sel, rd.
  - Phase 2, INST_LOAD: sel, rd, ld_ir.
  - Phase 3, IDLE: sel, rd, ld_ir.
  - Phase 4, OP_ADDR: inc_pc; halt = (Opcode==HLT).
  - Phase 5, OP_FETCH: rd = ALUOP.
  - Phase 6, ALU_OP:
    - rd = ALUOP.
    - inc_pc = (Opcode==SKZ && SKZ_cmp).
    - Load_in = (Opcode==JMP).
    - data_e = (Opcode==STO).
  - Phase 7, STORE:
    - rd = ALUOP, ld_ac = ALUOP.
    - Load_in = (Opcode==JMP).
    - wr = data_e = (Opcode==STO).
- Advance: `phase` increments by 1 each clock while `En_cpu_in`=1 and `halted`=0. It wraps from 7 to 0.
- Retirement: `instr_count` increments at each 7→0 wrap and wraps modulo 2^CNT_W.
- Halt entry: a rising edge in phase 4 with Opcode==HLT and `En_cpu_in`=1 sets `halted`.
  - `phase` stays at 4.
  - The HLT instruction is not counted.
- Halted state:
  - All strobes are 0; `halt`=1 held.
  - `phase` frozen at 4.
  - Only `reset` exits this state.
- Enable low: `phase` and `instr_count` hold, and all strobes are forced to 0. `halt` still reflects `halted`. On re-enable, sequencing resumes from the held phase.

## Timing

- Reset asserted (`reset`=0), immediately and asynchronously:
  - `phase`=0, `halted`=0, `instr_count`=0.
  - All strobes 0, including `sel`, because enable gating applies during reset.
- First cycle after release with `En_cpu_in`=1: phase 0 strobes are active (`sel`=1).
- Instruction latency: exactly 8 clocks per instruction. The memory address is valid in phase 0, the IR is loaded by the edge ending phase 3, and the PC is updated at the end of phase 4.
- SKZ taken: the second `inc_pc` occurs in phase 6, so the PC advances by 2 in total.
- JMP: `Load_in` is high in phases 6 and 7, overriding the phase-4 increment.
- `SKZ_cmp` is sampled only in phase 6. It must be stable from the phase-5 edge.
- `En_cpu_in` dropping mid-instruction holds the current phase; no strobe pulse is lost or duplicated.
- Reset mid-instruction aborts the instruction; the next fetch starts at phase 0.

## Test plan

- Reset then enable, Opcode=ADD:
  - Phases step 0,1,…,7,0.
  - `ld_ir` is high in phases 2–3; `ld_ac` is high only in phase 7.
  - `instr_count`=1 after 8 clocks.
- Opcode=SKZ with SKZ_cmp=1 → `inc_pc` high in phases 4 and 6. With SKZ_cmp=0 → `inc_pc` high in phase 4 only.
- Opcode=JMP → `Load_in` high in phases 6 and 7. `rd`, `wr` and `ld_ac` stay 0 in phases 5–7.
- Opcode=STO → `data_e` high in phases 6–7, `wr` high in phase 7 only, `rd` low in phases 5–7.
- Opcode=HLT at phase 4:
  - `halt`=1, `phase` stuck at 4, strobes 0.
  - `instr_count` unchanged across 20 clocks.
  - Pulsing `reset` low returns `phase`=0 and `halt`=0.
- Drop `En_cpu_in` in phase 5 for 3 clocks:
  - `phase` stays 5 and all strobes are 0.
  - On re-enable, phase 6 follows.
  - Run 256 instructions: `instr_count` wraps to 0.
